// File: rtl/cpu_core_pkg.sv
// Shared definitions for the CPU core and its result checker: opcode
// constants, the checker state encoding and the channel codes.
package cpu_core_pkg;

  localparam logic [3:0] OPC_STORE = 4'b0100;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_REPORT = 2'd2,
    ST_DONE   = 2'd3
  } checker_state_t;

  localparam logic CHAN_STORE = 1'b0;
  localparam logic CHAN_OUT   = 1'b1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/checker_channel.sv
// One scoring channel of the result checker: expected-value RAM, a
// saturating result index, and the compare that yields match/overflow
// strobes for the current result.
module checker_channel #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int IDX_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              score,
  input  logic [DATA_W-1:0] act,
  output logic              match,
  output logic              overflow_hit,
  output logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] exp_data
);

  localparam int LA_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [0:(2**LA_W)-1];
  logic              at_end;

  assign at_end = (idx == IDX_W'(DEPTH));

  // Expected memory has no reset so a loaded program survives a reset.
  always_ff @(posedge clock) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) begin
      mem[wr_addr[LA_W-1:0]] <= wr_data;
    end
  end

  // Result index: cleared per run, saturates at DEPTH instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (score && !at_end) begin
      idx <= idx + 1'b1;
    end
  end

  assign exp_data     = at_end ? '0 : mem[idx[LA_W-1:0]];
  assign match        = score && !at_end && (act == exp_data);
  assign overflow_hit = score && at_end;

endmodule

// File: rtl/cpu_result_checker.sv
// Hardware result checker for cpu_core: scores results on a store and an
// output channel against preloaded expected values and registers a
// pass/fail verdict when the program completes.
// Optional macro CPU_CHECKER_FAIL_LOG_EN builds the first-failure record.
//
// Handshake: cpu_valid qualifies cpu_out/opcode for exactly one clock;
// there is no ready, the checker observes every valid cycle (results are
// only scored in RUN). exp_wr_en is a single-cycle write strobe honoured
// in LOAD and DONE only.
module cpu_result_checker
  import cpu_core_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              OPC_W        = 4,
  parameter int              STORE_DEPTH  = 8,
  parameter int              OUT_DEPTH    = 2,
  parameter logic [OPC_W-1:0] STORE_OPCODE = OPC_W'(OPC_STORE),
  localparam int MAX_DEPTH = max_int(STORE_DEPTH, OUT_DEPTH),
  localparam int ADDR_W    = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1,
  localparam int IDX_W     = $clog2(MAX_DEPTH + 1),
  localparam int CNT_W     = $clog2(STORE_DEPTH + OUT_DEPTH + 1) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              arm,
  input  logic              cpu_valid,
  input  logic [DATA_W-1:0] cpu_out,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              cpu_done,
  input  logic              exp_wr_en,
  input  logic              exp_wr_chan,
  input  logic [ADDR_W-1:0] exp_wr_addr,
  input  logic [DATA_W-1:0] exp_wr_data,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              overflow,
  output logic              busy,
  output logic              verdict_valid,
  output logic              all_pass,
  output logic              first_fail_chan,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_act,
  output checker_state_t    state
);

  checker_state_t state_next;
  logic           done_q;
  logic           done_rise;
  logic           arm_ok;
  logic           wr_ok;
  logic           score;
  logic           score_store, score_out;
  logic           store_match, out_match;
  logic           store_ovf, out_ovf;
  logic [IDX_W-1:0]  store_idx, out_idx;
  logic [DATA_W-1:0] store_exp, out_exp;
  logic           hit_match, hit_ovf, hit_fail;

  assign done_rise   = cpu_done && !done_q;
  assign arm_ok      = arm && ((state == ST_LOAD) || (state == ST_DONE));
  assign wr_ok       = exp_wr_en && ((state == ST_LOAD) || (state == ST_DONE));
  assign score       = cpu_valid && (state == ST_RUN);
  assign score_store = score && (opcode == STORE_OPCODE);
  assign score_out   = score && (opcode != STORE_OPCODE);
  assign hit_match   = store_match || out_match;
  assign hit_ovf     = store_ovf || out_ovf;
  assign hit_fail    = score && !hit_match;
  assign busy        = (state == ST_RUN) || (state == ST_REPORT);

  checker_channel #(
    .DATA_W(DATA_W), .DEPTH(STORE_DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) u_store (
    .clock(clock), .reset(reset), .clear(arm_ok),
    .wr_en(wr_ok && (exp_wr_chan == CHAN_STORE)),
    .wr_addr(exp_wr_addr), .wr_data(exp_wr_data),
    .score(score_store), .act(cpu_out),
    .match(store_match), .overflow_hit(store_ovf),
    .idx(store_idx), .exp_data(store_exp)
  );

  checker_channel #(
    .DATA_W(DATA_W), .DEPTH(OUT_DEPTH), .ADDR_W(ADDR_W), .IDX_W(IDX_W)
  ) u_out (
    .clock(clock), .reset(reset), .clear(arm_ok),
    .wr_en(wr_ok && (exp_wr_chan == CHAN_OUT)),
    .wr_addr(exp_wr_addr), .wr_data(exp_wr_data),
    .score(score_out), .act(cpu_out),
    .match(out_match), .overflow_hit(out_ovf),
    .idx(out_idx), .exp_data(out_exp)
  );

  // State register plus the registered cpu_done used for rise detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_LOAD;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      done_q <= cpu_done;
    end
  end

  // Next-state: arm starts a run, a cpu_done rise ends it, REPORT lasts one cycle.
  always_comb begin
    state_next = state;
    case (state)
      ST_LOAD:   if (arm) state_next = ST_RUN;
      ST_RUN:    if (done_rise) state_next = ST_REPORT;
      ST_REPORT: state_next = ST_DONE;
      ST_DONE:   if (arm) state_next = ST_RUN;
      default:   state_next = ST_LOAD;
    endcase
  end

  // Saturating pass/fail counters and the sticky overflow flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass_count <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
    end else if (arm_ok) begin
      pass_count <= '0;
      fail_count <= '0;
      overflow   <= 1'b0;
    end else if (score) begin
      if (hit_match) begin
        if (pass_count != '1) pass_count <= pass_count + 1'b1;
      end else begin
        if (fail_count != '1) fail_count <= fail_count + 1'b1;
      end
      if (hit_ovf) overflow <= 1'b1;
    end
  end

  // Verdict is taken from the frozen counters on the REPORT->DONE edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      verdict_valid <= 1'b0;
      all_pass      <= 1'b0;
    end else if (arm_ok) begin
      verdict_valid <= 1'b0;
      all_pass      <= 1'b0;
    end else if (state == ST_REPORT) begin
      verdict_valid <= 1'b1;
      all_pass      <= (pass_count == CNT_W'(STORE_DEPTH + OUT_DEPTH)) &&
                       (fail_count == '0) && !overflow;
    end
  end

`ifdef CPU_CHECKER_FAIL_LOG_EN
  logic ff_seen;

  // Capture the first mismatch/overflow of a run; overflow has no expected value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ff_seen         <= 1'b0;
      first_fail_chan <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_exp  <= '0;
      first_fail_act  <= '0;
    end else if (arm_ok) begin
      ff_seen         <= 1'b0;
      first_fail_chan <= 1'b0;
      first_fail_idx  <= '0;
      first_fail_exp  <= '0;
      first_fail_act  <= '0;
    end else if (hit_fail && !ff_seen) begin
      ff_seen         <= 1'b1;
      first_fail_chan <= score_out ? CHAN_OUT : CHAN_STORE;
      first_fail_idx  <= score_out ? out_idx : store_idx;
      first_fail_exp  <= hit_ovf ? '0 : (score_out ? out_exp : store_exp);
      first_fail_act  <= cpu_out;
    end
  end
`else
  logic unused_log;

  assign unused_log      = ^{store_idx, out_idx, store_exp, out_exp};
  assign first_fail_chan = 1'b0;
  assign first_fail_idx  = '0;
  assign first_fail_exp  = '0;
  assign first_fail_act  = '0;
`endif

endmodule

// File: tb/tb_cpu_result_checker.sv
// Directed bench for cpu_result_checker: nominal, mismatch, overflow,
// missing-result, coincident-event and mid-run reset scenarios.
module tb_cpu_result_checker;
  import cpu_core_pkg::*;

  localparam int DATA_W = 8;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;

  logic              clock = 1'b0;
  logic              reset;
  logic              arm;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_out;
  logic [3:0]        opcode;
  logic              cpu_done;
  logic              exp_wr_en;
  logic              exp_wr_chan;
  logic [2:0]        exp_wr_addr;
  logic [DATA_W-1:0] exp_wr_data;
  logic [CNT_W-1:0]  pass_count;
  logic [CNT_W-1:0]  fail_count;
  logic              overflow;
  logic              busy;
  logic              verdict_valid;
  logic              all_pass;
  logic              first_fail_chan;
  logic [IDX_W-1:0]  first_fail_idx;
  logic [DATA_W-1:0] first_fail_exp;
  logic [DATA_W-1:0] first_fail_act;
  checker_state_t    state;

  int checks   = 0;
  int failures = 0;

  logic [7:0] st_v [8] = '{8'd4, 8'd1, 8'd5, 8'd6, 8'd8, 8'd4, 8'd3, 8'd2};
  logic [7:0] out_v[2] = '{8'd1, 8'd0};

  cpu_result_checker dut (
    .clock(clock), .reset(reset), .arm(arm), .cpu_valid(cpu_valid),
    .cpu_out(cpu_out), .opcode(opcode), .cpu_done(cpu_done),
    .exp_wr_en(exp_wr_en), .exp_wr_chan(exp_wr_chan),
    .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .pass_count(pass_count), .fail_count(fail_count), .overflow(overflow),
    .busy(busy), .verdict_valid(verdict_valid), .all_pass(all_pass),
    .first_fail_chan(first_fail_chan), .first_fail_idx(first_fail_idx),
    .first_fail_exp(first_fail_exp), .first_fail_act(first_fail_act),
    .state(state)
  );

  // Clock and reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic load(input logic chan, input logic [2:0] addr, input logic [7:0] d);
    exp_wr_en = 1'b1; exp_wr_chan = chan; exp_wr_addr = addr; exp_wr_data = d;
    tick();
    exp_wr_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] opc, input logic [7:0] d);
    cpu_valid = 1'b1; opcode = opc; cpu_out = d;
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic send_stores();
    for (int i = 0; i < 8; i++) send(4'b0100, st_v[i]);
  endtask

  // Raises cpu_done, passes edge N (REPORT) and edge N+1 (DONE).
  task automatic finish_run(input string tag);
    cpu_done = 1'b1;
    tick();
    chk({tag, "_report_state"}, 32'(state), 32'(ST_REPORT));
    chk({tag, "_report_vv"}, 32'(verdict_valid), 0);
    tick();
    chk({tag, "_done_state"}, 32'(state), 32'(ST_DONE));
    chk({tag, "_vv"}, 32'(verdict_valid), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
    cpu_done = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arm = 0; cpu_valid = 0; cpu_out = 0; opcode = 0; cpu_done = 0;
    exp_wr_en = 0; exp_wr_chan = 0; exp_wr_addr = 0; exp_wr_data = 0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(ST_LOAD));
    chk("rst_pass", 32'(pass_count), 0);
    chk("rst_fail", 32'(fail_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vv", 32'(verdict_valid), 0);
    chk("rst_ffact", 32'(first_fail_act), 0);
    reset = 1'b0;
    tick();

    // Load expected values
    for (int i = 0; i < 8; i++) load(CHAN_STORE, 3'(i), st_v[i]);
    for (int i = 0; i < 2; i++) load(CHAN_OUT, 3'(i), out_v[i]);

    // Nominal run
    pulse_arm();
    chk("nom_state_run", 32'(state), 32'(ST_RUN));
    chk("nom_busy", 32'(busy), 1);
    send(4'b0100, st_v[0]);
    chk("nom_pass_latency", 32'(pass_count), 1);
    for (int i = 1; i < 8; i++) send(4'b0100, st_v[i]);
    send(4'b0000, out_v[0]);
    send(4'b0000, out_v[1]);
    chk("nom_pass_pre", 32'(pass_count), 10);
    finish_run("nom");
    chk("nom_pass", 32'(pass_count), 10);
    chk("nom_fail", 32'(fail_count), 0);
    chk("nom_all_pass", 32'(all_pass), 1);

    // Mismatch: store #2 driven as 7
    pulse_arm();
    chk("mm_clr_vv", 32'(verdict_valid), 0);
    chk("mm_clr_pass", 32'(pass_count), 0);
    for (int i = 0; i < 8; i++) send(4'b0100, (i == 2) ? 8'd7 : st_v[i]);
    send(4'b0000, out_v[0]);
    send(4'b0000, out_v[1]);
    finish_run("mm");
    chk("mm_pass", 32'(pass_count), 9);
    chk("mm_fail", 32'(fail_count), 1);
    chk("mm_all_pass", 32'(all_pass), 0);
`ifdef CPU_CHECKER_FAIL_LOG_EN
    chk("mm_ff_chan", 32'(first_fail_chan), 0);
    chk("mm_ff_idx", 32'(first_fail_idx), 2);
    chk("mm_ff_exp", 32'(first_fail_exp), 5);
    chk("mm_ff_act", 32'(first_fail_act), 7);
`endif

    // Overflow: 9th store (value 4 would match entry 0 if the index wrapped)
    pulse_arm();
    send_stores();
    send(4'b0100, 8'd4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_fail", 32'(fail_count), 1);
    chk("ovf_pass", 32'(pass_count), 8);
    send(4'b0100, 8'd4);
    chk("ovf_sat_pass", 32'(pass_count), 8);
    chk("ovf_sat_fail", 32'(fail_count), 2);
`ifdef CPU_CHECKER_FAIL_LOG_EN
    chk("ovf_ff_idx", 32'(first_fail_idx), 8);
    chk("ovf_ff_exp", 32'(first_fail_exp), 0);
    chk("ovf_ff_act", 32'(first_fail_act), 4);
`endif
    send(4'b0000, out_v[0]);
    send(4'b0000, out_v[1]);
    finish_run("ovf");
    chk("ovf_pass_end", 32'(pass_count), 10);
    chk("ovf_all_pass", 32'(all_pass), 0);

    // Missing result: only the first output result
    pulse_arm();
    chk("miss_ovf_clr", 32'(overflow), 0);
    send_stores();
    send(4'b0000, out_v[0]);
    finish_run("miss");
    chk("miss_pass", 32'(pass_count), 9);
    chk("miss_fail", 32'(fail_count), 0);
    chk("miss_all_pass", 32'(all_pass), 0);

    // Coincident: last result with the cpu_done rise, arm during REPORT
    pulse_arm();
    send_stores();
    send(4'b0000, out_v[0]);
    cpu_valid = 1'b1; opcode = 4'b0000; cpu_out = out_v[1]; cpu_done = 1'b1;
    tick();
    cpu_valid = 1'b0;
    chk("coin_state_report", 32'(state), 32'(ST_REPORT));
    chk("coin_pass", 32'(pass_count), 10);
    arm = 1'b1;
    tick();
    arm = 1'b0; cpu_done = 1'b0;
    chk("coin_arm_ignored", 32'(state), 32'(ST_DONE));
    chk("coin_vv", 32'(verdict_valid), 1);
    chk("coin_all_pass", 32'(all_pass), 1);
    send(4'b0100, 8'd99);
    chk("done_ignores_pass", 32'(pass_count), 10);
    chk("done_ignores_fail", 32'(fail_count), 0);

    // Reset mid-run, then replay without reloading
    pulse_arm();
    for (int i = 0; i < 4; i++) send(4'b0100, st_v[i]);
    chk("mid_pass_pre", 32'(pass_count), 4);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pass", 32'(pass_count), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_state", 32'(state), 32'(ST_LOAD));
    chk("mid_rst_vv", 32'(verdict_valid), 0);
    #2 reset = 1'b0;
    tick();
    pulse_arm();
    send_stores();
    send(4'b0000, out_v[0]);
    send(4'b0000, out_v[1]);
    finish_run("replay");
    chk("replay_pass", 32'(pass_count), 10);
    chk("replay_all_pass", 32'(all_pass), 1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
